// File: rtl/interleaver_pkg.sv
`default_nettype none
// Shared constants, controller states and block-size helper for the QPP interleaver path.
package interleaver_pkg;

  localparam int unsigned K_SMALL = 1056;
  localparam int unsigned K_LARGE = 6144;

  localparam int unsigned F1_1056 = 17;
  localparam int unsigned F2_1056 = 66;
  localparam int unsigned F1_6144 = 263;
  localparam int unsigned F2_6144 = 480;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    DRAIN  = 2'd3
  } ctrl_state_t;

  function automatic int unsigned words_per_block(input logic k6144, input int unsigned w);
    return (k6144 ? K_LARGE : K_SMALL) / w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/interleaver_block_ctrl.sv
`default_nettype none
// Block sequencer around the combinational QPP interleaver: load cin word by word,
// let the permutation settle, capture cout, then stream the permuted block out.
module interleaver_block_ctrl
  import interleaver_pkg::*;
#(
  parameter int unsigned W             = 8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic               in_sop,
  input  logic               in_k6144,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic               out_last,
  output logic               busy,
  output logic               err,
  output logic [K_LARGE-1:0] il_cin,
  output logic               il_k_eq_6144,
  input  logic [K_LARGE-1:0] il_cout
);

  localparam int unsigned CNT_NEED = $clog2(K_LARGE / W + 1);
  localparam int unsigned CNT_W    = (CNT_NEED > 11) ? CNT_NEED : 11;

  localparam logic [CNT_W-1:0] LAST_SMALL = CNT_W'(words_per_block(1'b0, W) - 1);
  localparam logic [CNT_W-1:0] LAST_LARGE = CNT_W'(words_per_block(1'b1, W) - 1);
  localparam logic [3:0]       SCNT_LAST  = 4'(SETTLE_CYCLES - 1);

  ctrl_state_t        state, next_state;
  logic [CNT_W-1:0]   wcnt, rcnt;
  logic [3:0]         scnt;
  logic [K_LARGE-1:0] cap;
  logic [CNT_W-1:0]   n_last;
  logic               start_blk, write_word, bad_sop, capture;
  logic               single_word;

  assign n_last      = il_k_eq_6144 ? LAST_LARGE : LAST_SMALL;
  assign single_word = (words_per_block(in_k6144, W) == 1);
  assign out_data    = cap[rcnt*W +: W];
  assign out_last    = out_valid && (rcnt == n_last);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    start_blk  = 1'b0;
    write_word = 1'b0;
    bad_sop    = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          if (in_sop) begin
            start_blk  = 1'b1;
            next_state = single_word ? SETTLE : LOAD;
          end else begin
            bad_sop = 1'b1;
          end
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // A new start-of-packet abandons the partial block and restarts with this word.
          if (in_sop) begin
            start_blk  = 1'b1;
            bad_sop    = 1'b1;
            next_state = single_word ? SETTLE : LOAD;
          end else begin
            write_word = 1'b1;
            if (wcnt == n_last) next_state = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (scnt == SCNT_LAST) begin
          capture    = 1'b1;
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (rcnt == n_last)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      il_cin       <= '0;
      il_k_eq_6144 <= 1'b0;
      cap          <= '0;
      wcnt         <= '0;
      scnt         <= '0;
      rcnt         <= '0;
      err          <= 1'b0;
    end else begin
      err <= bad_sop;
      if (start_blk) begin
        il_k_eq_6144   <= in_k6144;
        il_cin         <= '0;
        il_cin[W-1:0]  <= in_data;
        wcnt           <= CNT_W'(1);
        scnt           <= '0;
      end else if (write_word) begin
        il_cin[wcnt*W +: W] <= in_data;
        wcnt                <= wcnt + 1'b1;
        scnt                <= '0;
      end
      if (state == SETTLE) scnt <= scnt + 1'b1;
      if (capture) begin
        cap  <= il_cout;
        rcnt <= '0;
      end else if (out_valid && out_ready) begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interleaver_block_ctrl.sv
`default_nettype none
// Self-checking bench: behavioural QPP interleaver beside the controller, directed + random blocks.
module tb_interleaver_block_ctrl;

  localparam int W  = 8;
  localparam int SC = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0, in_sop = 1'b0, in_k6144 = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid, out_last, busy, err, il_k_eq_6144;
  logic [W-1:0]  out_data;
  logic [6143:0] il_cin, il_cout;

  int checks = 0, errors = 0, cycle = 0, last_in = 0;

  interleaver_block_ctrl #(.W(W), .SETTLE_CYCLES(SC)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sop(in_sop), .in_k6144(in_k6144),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .err(err),
    .il_cin(il_cin), .il_k_eq_6144(il_k_eq_6144), .il_cout(il_cout)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  function automatic int pidx(input int i, input logic k6144);
    longint kk, f1, f2;
    kk = k6144 ? 6144 : 1056;
    f1 = k6144 ? 263 : 17;
    f2 = k6144 ? 480 : 66;
    return int'((f1 * i + f2 * longint'(i) * i) % kk);
  endfunction

  function automatic logic [6143:0] ref_perm(input logic [6143:0] blk, input logic k6144);
    logic [6143:0] r;
    r = '0;
    for (int i = 0; i < (k6144 ? 6144 : 1056); i++) r[pidx(i, k6144)] = blk[i];
    return r;
  endfunction

  // Combinational interleaver model driving the controller's cout input.
  always_comb begin
    il_cout = '0;
    for (int i = 0; i < 6144; i++)
      if (il_k_eq_6144 || i < 1056) il_cout[pidx(i, il_k_eq_6144)] = il_cin[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready), 1);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_last"},  32'(out_last), 0);
    chk({tag, "_busy"},      32'(busy), 0);
    chk({tag, "_err"},       32'(err), 0);
    chk({tag, "_k"},         32'(il_k_eq_6144), 0);
    chk({tag, "_cin"},       32'(|il_cin), 0);
  endtask

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic push(input logic [W-1:0] d, input logic sop, input logic k);
    int guard = 0;
    in_valid = 1'b1; in_data = d; in_sop = sop; in_k6144 = k;
    while (!in_ready && guard < 200) begin @(negedge clock); guard++; end
    chk("push_ready", 32'(in_ready), 1);
    last_in = cycle;
    @(negedge clock);
  endtask

  task automatic send_block(input logic k, input logic [6143:0] blk, input int nsend,
                            input bit expect_err);
    for (int n = 0; n < nsend; n++) begin
      push(blk[n*W +: W], n == 0, k);
      if (n == 0 && expect_err) begin
        chk("restart_err", 32'(err), 1);
        chk("restart_busy", 32'(busy), 1);
      end
    end
    in_valid = 1'b0; in_sop = 1'b0;
  endtask

  task automatic drain(input int nw, input logic [6143:0] expv, input bit stall,
                       input bit chk_lat, input int stop_at);
    int m = 0, guard = 0;
    bit first = 1, was_stall = 0;
    logic [W-1:0] hold_d;
    logic hold_l;
    while (m < stop_at && guard < 20000) begin
      if (out_valid) begin
        if (first && chk_lat) chk("latency", 32'(cycle - last_in), SC + 1);
        first = 0;
        if (was_stall) begin
          chk("stall_data", 32'(out_data), 32'(hold_d));
          chk("stall_last", 32'(out_last), 32'(hold_l));
        end
        chk("drain_in_ready", 32'(in_ready), 0);
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) begin
          chk($sformatf("word%0d", m), 32'(out_data), 32'(expv[m*W +: W]));
          chk($sformatf("last%0d", m), 32'(out_last), 32'(m == nw - 1));
          m++;
          was_stall = 0;
        end else begin
          was_stall = 1; hold_d = out_data; hold_l = out_last;
        end
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clock);
      guard++;
    end
    chk("drain_count", 32'(m), 32'(stop_at));
    if (stop_at == nw) begin
      chk("post_out_valid", 32'(out_valid), 0);
      chk("post_busy", 32'(busy), 0);
      chk("post_err", 32'(err), 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic rand_block(output logic [6143:0] b, input logic k);
    b = '0;
    for (int i = 0; i < (k ? 192 : 33); i++) b[i*32 +: 32] = $urandom;
  endtask

  logic [6143:0] blk, junk, expv;

  initial begin
    repeat (2) @(negedge clock);
    chk_reset("rst0");
    reset = 1'b0;
    @(negedge clock);

    // Single bit 1 at K=1056 lands on bit 83
    blk = '0; blk[1] = 1'b1;
    send_block(1'b0, blk, 132, 0);
    expv = '0; expv[83] = 1'b1;
    drain(132, expv, 0, 1, 132);

    // Single bit 1 at K=6144 lands on bit 743
    blk = '0; blk[1] = 1'b1;
    send_block(1'b1, blk, 768, 0);
    chk("k6144_flag", 32'(il_k_eq_6144), 1);
    expv = '0; expv[743] = 1'b1;
    drain(768, expv, 0, 1, 768);

    // Random K=1056 block
    rand_block(blk, 1'b0);
    send_block(1'b0, blk, 132, 0);
    drain(132, ref_perm(blk, 1'b0), 0, 1, 132);

    // Stray word in IDLE
    push(8'h5a, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("idle_err", 32'(err), 1);
    chk("idle_busy", 32'(busy), 0);
    @(negedge clock);
    chk("idle_err_clear", 32'(err), 0);
    chk("idle_busy2", 32'(busy), 0);

    // Restart at word 50
    rand_block(junk, 1'b1);
    send_block(1'b1, junk, 50, 0);
    rand_block(blk, 1'b0);
    send_block(1'b0, blk, 132, 1);
    drain(132, ref_perm(blk, 1'b0), 0, 1, 132);

    // Random back-pressure with an upstream word waiting
    rand_block(blk, 1'b1);
    send_block(1'b1, blk, 768, 0);
    in_valid = 1'b1; in_sop = 1'b0; in_data = 8'hc3;
    drain(768, ref_perm(blk, 1'b1), 1, 0, 768);

    // Reset during LOAD
    rand_block(junk, 1'b1);
    send_block(1'b1, junk, 40, 0);
    reset = 1'b1;
    #1 chk_reset("rst_load");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset during DRAIN
    rand_block(junk, 1'b0);
    send_block(1'b0, junk, 132, 0);
    drain(132, ref_perm(junk, 1'b0), 0, 1, 5);
    reset = 1'b1;
    #1 chk_reset("rst_drain");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    rand_block(blk, 1'b1);
    send_block(1'b1, blk, 768, 0);
    drain(768, ref_perm(blk, 1'b1), 0, 1, 768);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
